// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised reorder buffer with in-order dispatch/commit and out-of-order writeback
// Optional feature macro: ROB_PARTIAL_FLUSH_EN (flush keeps entries up to and including flush_tag)
module rob_param #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 48,
  parameter int REG_W  = 5,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [REG_W-1:0]  disp_dest,
  input  logic              disp_is_mem,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [IDX_W-1:0]  disp_tag,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              commit_valid,
  input  logic              commit_ack,
  output logic [IDX_W-1:0]  commit_tag,
  output logic              commit_is_mem,
  output logic [REG_W-1:0]  commit_dest,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data,
  input  logic              flush,
`ifdef ROB_PARTIAL_FLUSH_EN
  input  logic [IDX_W-1:0]  flush_tag,
`endif
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  ready_q;
  logic [DEPTH-1:0]  is_mem_q;
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [IDX_W:0]    count_q;

  logic disp_fire;
  logic commit_fire;
  logic wb_hit;

`ifdef ROB_PARTIAL_FLUSH_EN
  // Distance from head to the surviving branch; entries further than this are younger and get squashed.
  logic [IDX_W-1:0] keep_off;
  assign keep_off = flush_tag - head_q;
`endif

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A full ROB refuses dispatch even when the head retires this cycle: slots are never reused same-cycle.
  assign disp_ready = rst_n && !full;
  assign disp_tag   = tail_q;
  assign disp_fire  = disp_valid && disp_ready && !flush;

  assign commit_valid  = rst_n && !empty && valid_q[head_q] && ready_q[head_q] && !flush;
  assign commit_fire   = commit_valid && commit_ack;
  assign commit_tag    = head_q;
  assign commit_is_mem = is_mem_q[head_q];
  assign commit_dest   = dest_q[head_q];
  assign commit_addr   = addr_q[head_q];
  assign commit_data   = data_q[head_q];

  // Writebacks to squashed or never-allocated slots are dropped.
  assign wb_hit = wb_valid && valid_q[wb_tag] && !flush;

  // Control state: occupancy bits, pointers and count; reset beats flush beats normal traffic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
`ifdef ROB_PARTIAL_FLUSH_EN
      for (int i = 0; i < DEPTH; i++) begin
        if ((IDX_W'(i) - head_q) > keep_off) begin
          valid_q[i] <= 1'b0;
          ready_q[i] <= 1'b0;
        end
      end
      tail_q  <= flush_tag + 1'b1;
      count_q <= {1'b0, keep_off} + 1'b1;
`else
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
`endif
    end else begin
      if (disp_fire) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      if (wb_hit) begin
        ready_q[wb_tag] <= 1'b1;
      end
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (disp_fire && !commit_fire) begin
        count_q <= count_q + 1'b1;
      end else if (!disp_fire && commit_fire) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Payload storage needs no reset; it is only observed once the matching valid/ready bits are set.
  always_ff @(posedge clk) begin
    if (rst_n && disp_fire) begin
      is_mem_q[tail_q] <= disp_is_mem;
      dest_q[tail_q]   <= disp_dest;
      addr_q[tail_q]   <= disp_addr;
    end
    if (rst_n && wb_hit) begin
      data_q[wb_tag] <= wb_data;
    end
  end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
Parametrised reorder buffer, next generation of the core's 8-entry ROB. It sits between dispatch and the register/memory commit paths. Entries are allocated in order through a valid/ready handshake, completed out of order by tagged writeback, and retired strictly in order through a valid/ack commit port. Adds configurable depth and width, occupancy/full/empty status, and mispredict flush.

Parameters:
DEPTH, 8, number of entries; power of two, >=2; IDX_W = $clog2(DEPTH) derived localparam
DATA_W, 64, result width
ADDR_W, 48, memory address width
REG_W, 5, destination register index width

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset
disp_valid  input  1  dispatch request
disp_ready  output  1  ROB can accept (= !full && rst_n)
disp_dest  input  REG_W  destination register
disp_is_mem  input  1  entry commits to memory (HasAddress)
disp_addr  input  ADDR_W  memory address
disp_tag  output  IDX_W  tail index allocated on accept; returned to RS
wb_valid  input  1  result writeback
wb_tag  input  IDX_W  entry being completed
wb_data  input  DATA_W  result value
commit_valid  output  1  head entry valid and ready
commit_ack  input  1  consumer retires head this cycle
commit_tag  output  IDX_W  head index
commit_is_mem  output  1  head is memory op
commit_dest  output  REG_W  head destination register
commit_addr  output  ADDR_W  head memory address
commit_data  output  DATA_W  head result
flush  input  1  mispredict; squash entries
count  output  IDX_W+1  occupancy 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Per-entry state: valid, ready, is_mem, dest, addr, data. head/tail pointers are IDX_W bits and wrap DEPTH-1 -> 0.
- Reset (rst_n low at posedge): all valid/ready bits cleared; head=tail=0; count=0. While rst_n is low, disp_ready=0 and commit_valid=0. After reset: empty=1, full=0, disp_tag=0, commit_* payload don't-care.
- Dispatch: accepted on posedge when disp_valid && disp_ready. disp_tag equals tail combinationally in the accept cycle. Entry written with valid=1, ready=0. tail advances.
- Writeback: on wb_valid, if entry[wb_tag].valid, data is stored and ready set to 1. Writeback to an invalid entry is silently ignored. commit_valid is seen no earlier than the cycle after the writeback (1-cycle latency).
- Commit: commit_valid = !empty && entry[head].valid && entry[head].ready && !flush. Payload is driven from entry[head] combinationally. On commit_valid && commit_ack, entry[head].valid is cleared and head advances. Without ack, the head is held and its outputs stay stable.
- Full: disp_ready=0 even if a commit occurs in the same cycle. No same-cycle slot reuse.
- count: +1 on accept, -1 on commit, unchanged if both occur in the same cycle.
- Writeback and commit may target different entries in the same cycle. A writeback to head in the same cycle as a commit of head cannot occur, because head must already be ready to commit.
- flush: highest priority. All valid/ready bits are cleared, head=tail=0, count=0. Dispatch, writeback and commit in that cycle are ignored, and commit_valid is masked low.
- Priority within a cycle: reset > flush > {dispatch, writeback, commit}. The last three are independent.

Optional Feature:
ROB_PARTIAL_FLUSH_EN
- Defined: adds input flush_tag [IDX_W-1:0], which names the mispredicted branch entry (must be valid). flush clears only the entries strictly younger than flush_tag (from flush_tag+1 to tail-1, wrapping). tail is set to flush_tag+1 and count is recomputed as the distance from head to the new tail. Older entries, including the branch itself, are kept. A commit in the same cycle is still blocked.
- Undefined: no flush_tag port; flush is a full clear as above.

Test Plan:
- Reset, then 8 dispatches, no writeback -> disp_tag 0..7, count=8, full=1, disp_ready=0; a 9th disp_valid is not accepted.
- Fill to 8; writeback tags 3,1,0 with 0xA,0xB,0xC; hold commit_ack=1 -> commits tag0 0xC, then tag1 0xB, then stalls (tag2 not ready); tag3 commits only after a writeback to tag2.
- Full ROB with head ready, disp_valid=1 and commit_ack=1 in the same cycle -> commit occurs, dispatch not accepted, count 8->7; next cycle the dispatch is accepted with disp_tag=0.
- Wrap: 10 dispatch/commit pairs through 8 entries -> disp_tag sequence 0..7,0,1; commit order matches; count never exceeds 1.
- 5 entries live, flush=1 together with wb_valid and disp_valid -> next cycle count=0, empty=1, disp_tag=0, commit_valid=0. With ROB_PARTIAL_FLUSH_EN and flush_tag=2 -> count=3, disp_tag=3.
- rst_n low mid-operation (count=6) -> next cycle count=0, empty=1. disp_ready is 0 during reset and 1 after it.
